// File: rtl/tipi_pi_link_seq_pkg.sv
// Shared types for the Pi-side link sequencer: FSM state encoding and sticky error bit positions.
// No logic; imported by the sequencer top.
package tipi_pi_link_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RX   = 2'd1,
    ST_TX   = 2'd2
  } state_t;

  localparam int ERR_W       = 3;
  localparam int ERR_OVERRUN = 0;
  localparam int ERR_SHORT   = 1;
  localparam int ERR_RTABORT = 2;

endpackage

// File: rtl/tipi_pi_link_seq_sync_edge.sv
// Purpose: multi-flop synchronizer for one async Pi pin, with synced level and edge pulses.
// Latency: level valid SYNC_STAGES cycles after the pin; rise/fall pulse in the same cycle as the level change.
// Backpressure: none; pulses are single-cycle and are masked while en is low.
module tipi_pi_link_seq_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic pin,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pin};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  // Edges come only from flop outputs, so the pulses are glitch-free.
  assign level = sync_q[SYNC_STAGES-1];
  assign rise  = en &  level & ~prev_q;
  assign fall  = en & ~level &  prev_q;

endmodule

// File: rtl/tipi_pi_link_seq.sv
// Purpose: sequences Pi link strobes into one-cycle load/shift/latch pulses and tracks sticky errors.
// Latency: strobes appear SYNC_STAGES+1 ti_ph3 cycles after the Pi pin edge.
// Backpressure: none; the Pi must respect minimum pulse widths, and excess bits are flagged.
module tipi_pi_link_seq #(
  parameter int SYNC_STAGES = 2,
  parameter int XFER_BITS   = 8,
  parameter int CNT_W       = 4
) (
  input  logic       ti_ph3,
  input  logic       ti_reset_n,
  input  logic       r_clk,
  input  logic       r_le,
  input  logic       r_rt,
  input  logic       r_dc,
  input  logic       err_clr,
  output logic       so_load,
  output logic       so_sel,
  output logic       so_shift,
  output logic       si_shift,
  output logic       rd_le,
  output logic       rc_le,
  output logic       busy,
  output logic       xfer_done,
  output logic [2:0] err
);
  import tipi_pi_link_seq_pkg::*;

  localparam int SUP_W = $clog2(SYNC_STAGES + 2);

  logic [SUP_W-1:0] sup_cnt_q;
  logic             edge_en;

  logic clk_lvl, clk_e, clk_fall;
  logic le_lvl, le_e, le_fall;
  logic rt_lvl, rt_rise, rt_fall, rt_t;
  logic dc_lvl, dc_rise, dc_fall;
  logic unused_sig;

  state_t           state_q, state_nxt;
  logic [CNT_W-1:0] cnt_q, cnt_nxt;
  logic [ERR_W-1:0] err_q, err_set;
  logic             cnt_full, cnt_last;

  logic load_nxt, sel_nxt, so_shift_nxt, si_shift_nxt, rd_le_nxt, rc_le_nxt, done_nxt;

  // Hold off edge detection until the sync chains reflect the real pin levels.
  assign edge_en = (sup_cnt_q == SUP_W'(SYNC_STAGES + 1));

  always_ff @(posedge ti_ph3) begin
    if (!ti_reset_n) begin
      sup_cnt_q <= '0;
    end else if (!edge_en) begin
      sup_cnt_q <= sup_cnt_q + SUP_W'(1);
    end
  end

  tipi_pi_link_seq_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_clk (
    .clk(ti_ph3), .rst_n(ti_reset_n), .en(edge_en), .pin(r_clk),
    .level(clk_lvl), .rise(clk_e), .fall(clk_fall)
  );
  tipi_pi_link_seq_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_le (
    .clk(ti_ph3), .rst_n(ti_reset_n), .en(edge_en), .pin(r_le),
    .level(le_lvl), .rise(le_e), .fall(le_fall)
  );
  tipi_pi_link_seq_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_rt (
    .clk(ti_ph3), .rst_n(ti_reset_n), .en(edge_en), .pin(r_rt),
    .level(rt_lvl), .rise(rt_rise), .fall(rt_fall)
  );
  tipi_pi_link_seq_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_dc (
    .clk(ti_ph3), .rst_n(ti_reset_n), .en(edge_en), .pin(r_dc),
    .level(dc_lvl), .rise(dc_rise), .fall(dc_fall)
  );

  assign rt_t       = rt_rise | rt_fall;
  assign unused_sig = &{1'b0, clk_lvl, clk_fall, le_lvl, le_fall, dc_rise, dc_fall};

  assign cnt_full = (cnt_q == CNT_W'(XFER_BITS));
  assign cnt_last = (cnt_q == CNT_W'(XFER_BITS - 1));

  always_ff @(posedge ti_ph3) begin
    if (!ti_reset_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      err_q     <= '0;
      so_load   <= 1'b0;
      so_sel    <= 1'b0;
      so_shift  <= 1'b0;
      si_shift  <= 1'b0;
      rd_le     <= 1'b0;
      rc_le     <= 1'b0;
      xfer_done <= 1'b0;
    end else begin
      state_q   <= state_nxt;
      cnt_q     <= cnt_nxt;
      // A new error outranks a clear arriving in the same cycle.
      err_q     <= (err_q & ~{ERR_W{err_clr}}) | err_set;
      so_load   <= load_nxt;
      so_sel    <= sel_nxt;
      so_shift  <= so_shift_nxt;
      si_shift  <= si_shift_nxt;
      rd_le     <= rd_le_nxt;
      rc_le     <= rc_le_nxt;
      xfer_done <= done_nxt;
    end
  end

  always_comb begin
    state_nxt = state_q;
    cnt_nxt   = cnt_q;
    err_set   = '0;
    case (state_q)
      ST_IDLE: begin
        if (le_e) begin
          err_set[ERR_OVERRUN] = clk_e;
          if (rt_lvl) begin
            state_nxt = ST_TX;
            cnt_nxt   = '0;
          end else begin
            err_set[ERR_SHORT] = 1'b1;
          end
        end else if (clk_e && !rt_lvl) begin
          state_nxt = ST_RX;
          cnt_nxt   = CNT_W'(1);
        end
      end
      ST_RX: begin
        if (rt_t) begin
          state_nxt            = ST_IDLE;
          cnt_nxt              = '0;
          err_set[ERR_RTABORT] = 1'b1;
        end else if (le_e) begin
          err_set[ERR_OVERRUN] = clk_e;
          err_set[ERR_SHORT]   = !cnt_full;
          state_nxt            = ST_IDLE;
          cnt_nxt              = '0;
        end else if (clk_e) begin
          if (cnt_full) begin
            err_set[ERR_OVERRUN] = 1'b1;
          end else begin
            cnt_nxt = cnt_q + CNT_W'(1);
          end
        end
      end
      ST_TX: begin
        if (rt_t) begin
          state_nxt            = ST_IDLE;
          cnt_nxt              = '0;
          err_set[ERR_RTABORT] = 1'b1;
        end else if (le_e) begin
          err_set[ERR_OVERRUN] = clk_e;
          cnt_nxt              = '0;
        end else if (clk_e) begin
          if (cnt_last) begin
            state_nxt = ST_IDLE;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt_q + CNT_W'(1);
          end
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  always_comb begin
    load_nxt     = 1'b0;
    sel_nxt      = so_sel;
    so_shift_nxt = 1'b0;
    si_shift_nxt = 1'b0;
    rd_le_nxt    = 1'b0;
    rc_le_nxt    = 1'b0;
    done_nxt     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (le_e) begin
          if (rt_lvl) begin
            load_nxt = 1'b1;
            sel_nxt  = dc_lvl;
          end
        end else if (clk_e && !rt_lvl) begin
          si_shift_nxt = 1'b1;
        end
      end
      ST_RX: begin
        if (!rt_t) begin
          if (le_e) begin
            rd_le_nxt = cnt_full & ~dc_lvl;
            rc_le_nxt = cnt_full &  dc_lvl;
            done_nxt  = cnt_full;
          end else if (clk_e) begin
            si_shift_nxt = 1'b1;
          end
        end
      end
      ST_TX: begin
        if (!rt_t) begin
          if (le_e) begin
            load_nxt = 1'b1;
            sel_nxt  = dc_lvl;
          end else if (clk_e) begin
            so_shift_nxt = 1'b1;
            done_nxt     = cnt_last;
          end
        end
      end
      default: ;
    endcase
  end

  assign busy = (state_q != ST_IDLE);
  assign err  = err_q;

endmodule

// File: tb/tb_tipi_pi_link_seq.sv
// Bench for the Pi link sequencer: expected strobe events are queued as pins are driven and
// matched in order as the design emits them; levels (err, busy) are checked directly.
module tb_tipi_pi_link_seq;

  logic       ti_ph3 = 1'b0;
  logic       ti_reset_n = 1'b0;
  logic       r_clk = 1'b0, r_le = 1'b0, r_rt = 1'b0, r_dc = 1'b0, err_clr = 1'b0;
  logic       so_load, so_sel, so_shift, si_shift, rd_le, rc_le, busy, xfer_done;
  logic [2:0] err;

  int n_cmp = 0;
  int n_bad = 0;

  // Event word: {so_load, so_sel-at-load, so_shift, si_shift, rd_le, rc_le, xfer_done}
  localparam logic [6:0] EV_LOAD_TD = 7'b1000000;
  localparam logic [6:0] EV_LOAD_TC = 7'b1100000;
  localparam logic [6:0] EV_SO      = 7'b0010000;
  localparam logic [6:0] EV_SO_DONE = 7'b0010001;
  localparam logic [6:0] EV_SI      = 7'b0001000;
  localparam logic [6:0] EV_RD      = 7'b0000101;
  localparam logic [6:0] EV_RC      = 7'b0000011;
  localparam logic [6:0] EV_NONE    = 7'b0000000;

  logic [6:0] exp_q[$];
  logic [6:0] mon_ev;

  tipi_pi_link_seq dut (
    .ti_ph3(ti_ph3), .ti_reset_n(ti_reset_n),
    .r_clk(r_clk), .r_le(r_le), .r_rt(r_rt), .r_dc(r_dc), .err_clr(err_clr),
    .so_load(so_load), .so_sel(so_sel), .so_shift(so_shift), .si_shift(si_shift),
    .rd_le(rd_le), .rc_le(rc_le), .busy(busy), .xfer_done(xfer_done), .err(err)
  );

  always #5 ti_ph3 = ~ti_ph3;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  always @(negedge ti_ph3) begin
    mon_ev = {so_load, so_load & so_sel, so_shift, si_shift, rd_le, rc_le, xfer_done};
    if (mon_ev != EV_NONE) begin
      if (exp_q.size() == 0) chk("unexpected_event", {25'd0, mon_ev}, 32'd0);
      else                   chk("event", {25'd0, mon_ev}, {25'd0, exp_q.pop_front()});
    end
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge ti_ph3);
  endtask

  task automatic clk_pulse(input logic [6:0] ev);
    if (ev != EV_NONE) exp_q.push_back(ev);
    r_clk = 1'b1; wait_cyc(4);
    r_clk = 1'b0; wait_cyc(4);
  endtask

  task automatic le_pulse(input logic [6:0] ev);
    if (ev != EV_NONE) exp_q.push_back(ev);
    r_le = 1'b1; wait_cyc(4);
    r_le = 1'b0; wait_cyc(4);
  endtask

  task automatic clear_err();
    err_clr = 1'b1; wait_cyc(1);
    err_clr = 1'b0; wait_cyc(1);
  endtask

  task automatic drain(input string tag);
    wait_cyc(6);
    chk(tag, exp_q.size(), 0);
    exp_q.delete();
  endtask

  initial begin
    wait_cyc(3);
    chk("reset_outputs", {so_load, so_sel, so_shift, si_shift, rd_le, rc_le, busy, xfer_done, err}, 0);
    ti_reset_n = 1'b1;
    wait_cyc(5);

    // Pi write of RD, with exact latency and width on the first bit
    r_rt = 1'b0; r_dc = 1'b0; wait_cyc(2);
    exp_q.push_back(EV_SI);
    r_clk = 1'b1; wait_cyc(2);
    chk("lat_early", si_shift, 0);
    wait_cyc(1);
    chk("lat_hit", si_shift, 1);
    wait_cyc(1);
    chk("width_one", si_shift, 0);
    r_clk = 1'b0; wait_cyc(4);
    chk("busy_rx", busy, 1);
    for (int i = 1; i < 8; i++) clk_pulse(EV_SI);
    le_pulse(EV_RD);
    drain("drain_write");
    chk("write_err", err, 3'b000);
    chk("write_busy", busy, 0);

    // Pi read of TC
    r_rt = 1'b1; r_dc = 1'b1; wait_cyc(2);
    le_pulse(EV_LOAD_TC);
    chk("busy_tx", busy, 1);
    for (int i = 0; i < 7; i++) clk_pulse(EV_SO);
    clk_pulse(EV_SO_DONE);
    drain("drain_read");
    chk("read_busy", busy, 0);
    chk("read_err", err, 3'b000);

    // Short write
    r_rt = 1'b0; r_dc = 1'b0; wait_cyc(2);
    for (int i = 0; i < 5; i++) clk_pulse(EV_SI);
    le_pulse(EV_NONE);
    drain("drain_short");
    chk("short_err", err, 3'b010);
    chk("short_busy", busy, 0);
    clear_err();
    chk("short_clr", err, 3'b000);

    // Overrun into RC
    r_dc = 1'b1; wait_cyc(2);
    for (int i = 0; i < 10; i++) clk_pulse(EV_SI);
    le_pulse(EV_RC);
    drain("drain_overrun");
    chk("overrun_err", err, 3'b001);
    clear_err();

    // Direction abort mid-receive
    r_dc = 1'b0; wait_cyc(2);
    for (int i = 0; i < 3; i++) clk_pulse(EV_SI);
    r_rt = 1'b1; wait_cyc(6);
    drain("drain_abort");
    chk("abort_err", err, 3'b100);
    chk("abort_busy", busy, 0);
    clear_err();

    // clk and le together: load wins, clk dropped and flagged
    exp_q.push_back(EV_LOAD_TD);
    r_clk = 1'b1; r_le = 1'b1; wait_cyc(4);
    r_clk = 1'b0; r_le = 1'b0; wait_cyc(4);
    chk("collide_err", err, 3'b001);
    chk("collide_busy", busy, 1);
    for (int i = 0; i < 7; i++) clk_pulse(EV_SO);
    clk_pulse(EV_SO_DONE);
    drain("drain_collide");
    chk("collide_idle", busy, 0);
    clear_err();

    // Reset during TX bit 4 with r_clk held high through release
    le_pulse(EV_LOAD_TD);
    for (int i = 0; i < 3; i++) clk_pulse(EV_SO);
    r_clk = 1'b1; wait_cyc(1);
    ti_reset_n = 1'b0; wait_cyc(1);
    chk("midrst_outputs", {so_load, so_sel, so_shift, si_shift, rd_le, rc_le, busy, xfer_done, err}, 0);
    ti_reset_n = 1'b1; wait_cyc(10);
    chk("midrst_busy", busy, 0);
    r_clk = 1'b0; wait_cyc(4);
    clk_pulse(EV_NONE);
    drain("drain_midrst");
    chk("midrst_err", err, 3'b000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
